// File: rtl/fft_bitrev_reorder_pkg.sv
// rtl/fft_bitrev_reorder_pkg.sv - shared FFT constants, read FSM states and bit-reverse helper
package fft_bitrev_reorder_pkg;

    localparam int FFT_LOG2N = 10;
    localparam int FFT_DW    = 24;
    localparam int FFT_HW    = FFT_DW / 2;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_t;

    function automatic logic [FFT_LOG2N-1:0] bitrev(input logic [FFT_LOG2N-1:0] a);
        logic [FFT_LOG2N-1:0] r;
        for (int i = 0; i < FFT_LOG2N; i++) begin
            r[i] = a[FFT_LOG2N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_sdp_ram.sv
// rtl/fft_sdp_ram.sv - simple dual-port RAM, one write port and one registered read port
module fft_sdp_ram #(
    parameter int AW = 11,
    parameter int DW = 24
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];

    // No reset on the array or read register so the tools can map this onto block RAM.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// rtl/fft_bitrev_reorder.sv - ping-pong buffer turning bit-reversed FFT frames into natural bin order
module fft_bitrev_reorder
    import fft_bitrev_reorder_pkg::*;
#(
    parameter int LOG2N = FFT_LOG2N,
    parameter int DW    = FFT_DW
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    input  logic [DW-1:0]    i_data,
    output logic             o_valid,
    output logic [DW-1:0]    o_data,
    output logic [LOG2N-1:0] o_index,
    output logic             o_last
);

    localparam logic [LOG2N-1:0] LAST_BIN = '1;

    logic [LOG2N-1:0] r_wcnt;
    logic             r_wbank;
    rd_state_t        r_state;
    logic [LOG2N-1:0] r_raddr;
    logic             r_rbank;
    logic             r_p_valid;
    logic [LOG2N-1:0] r_p_index;

    logic             w_accept;
    logic             w_wrap;
    logic [LOG2N-1:0] w_wrev;
    logic [DW-1:0]    w_rdata;

    assign w_accept = i_valid && !i_reset;
    assign w_wrap   = w_accept && (r_wcnt == LAST_BIN);

    always_comb begin
        w_wrev = '0;
        for (int i = 0; i < LOG2N; i++) begin
            w_wrev[i] = r_wcnt[LOG2N-1-i];
        end
    end

    fft_sdp_ram #(
        .AW (LOG2N + 1),
        .DW (DW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_accept),
        .i_waddr ({r_wbank, w_wrev}),
        .i_wdata (i_data),
        .i_re    (r_state == RD_READ),
        .i_raddr ({r_rbank, r_raddr}),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wcnt  <= '0;
            r_wbank <= 1'b0;
        end else if (w_accept) begin
            r_wcnt <= r_wcnt + 1'b1;
            if (w_wrap) begin
                r_wbank <= ~r_wbank;
            end
        end
    end

    // r_p_* tracks the address the RAM captured this edge; the output stage lags it by one edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= RD_IDLE;
            r_raddr   <= '0;
            r_rbank   <= 1'b0;
            r_p_valid <= 1'b0;
            r_p_index <= '0;
            o_valid   <= 1'b0;
            o_data    <= '0;
            o_index   <= '0;
            o_last    <= 1'b0;
        end else begin
            r_p_valid <= (r_state == RD_READ);
            r_p_index <= r_raddr;

            if (w_wrap) begin
                r_state <= RD_READ;
                r_raddr <= '0;
                r_rbank <= r_wbank;
            end else if (r_state == RD_READ) begin
                r_raddr <= r_raddr + 1'b1;
                if (r_raddr == LAST_BIN) begin
                    r_state <= RD_IDLE;
                end
            end

            o_valid <= r_p_valid;
            o_index <= r_p_index;
            o_last  <= r_p_valid && (r_p_index == LAST_BIN);
            if (r_p_valid) begin
                o_data <= w_rdata;
            end
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb/tb_fft_bitrev_reorder.sv - scoreboard bench for the bit-reverse reorder buffer
module tb_fft_bitrev_reorder;

    localparam int LOG2N = 3;
    localparam int N     = 1 << LOG2N;
    localparam int DW    = 24;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             iv  = 1'b0;
    logic [DW-1:0]    id  = '0;
    logic             o_valid;
    logic [DW-1:0]    o_data;
    logic [LOG2N-1:0] o_index;
    logic             o_last;

    fft_bitrev_reorder #(.LOG2N(LOG2N), .DW(DW)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_valid (iv),
        .i_data  (id),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_index (o_index),
        .o_last  (o_last)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        logic [DW-1:0] d;
        int            idx;
        bit            last;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] fbuf[N];
    int            wcnt_m        = 0;
    int            last_rst_edge = 1;
    int            checks        = 0;
    int            errors        = 0;
    bit            done          = 0;

    function automatic int rev(input int k);
        int r = 0;
        for (int b = 0; b < LOG2N; b++) r = r * 2 + ((k >> b) & 1);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
        end
    endtask

    // Inputs applied at a negedge are captured at edge e; the model books expected outputs by edge.
    task automatic drive(input bit v, input logic [DW-1:0] d, input bit r);
        int e;
        exp_t x;
        @(negedge clk);
        iv  = v;
        id  = d;
        rst = r;
        e   = edge_n + 1;
        if (r) begin
            wcnt_m = 0;
            last_rst_edge = e;
            while (sb.size() > 0 && sb[$].cyc >= e) void'(sb.pop_back());
        end else if (v) begin
            fbuf[wcnt_m] = d;
            wcnt_m++;
            if (wcnt_m == N) begin
                for (int m = 0; m < N; m++) begin
                    x.d    = fbuf[rev(m)];
                    x.idx  = m;
                    x.last = (m == N - 1);
                    x.cyc  = e + 2 + m;
                    sb.push_back(x);
                end
                wcnt_m = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, '0, 0);
    endtask

    task automatic frame(input int base);
        for (int k = 0; k < N; k++) drive(1, DW'(base + k), 0);
    endtask

    initial begin : monitor
        bit   ev;
        exp_t x;
        @(negedge clk);
        while (!done) begin
            ev = (sb.size() > 0) && (sb[0].cyc == edge_n);
            check("out_valid", 64'(o_valid), 64'(ev));
            if (ev) begin
                x = sb.pop_front();
                if (o_valid === 1'b1) begin
                    check("out_data", 64'(o_data), 64'(x.d));
                    check("out_index", 64'(o_index), 64'(x.idx));
                    check("out_last", 64'(o_last), 64'(x.last));
                end
            end else begin
                check("out_last_idle", 64'(o_last), 64'd0);
            end
            if (edge_n == last_rst_edge) begin
                check("reset_out_data", 64'(o_data), 64'd0);
                check("reset_out_index", 64'(o_index), 64'd0);
            end
            @(negedge clk);
        end
    end

    initial begin : stimulus
        drive(0, '0, 1);
        drive(0, '0, 1);

        frame(0);
        idle(12);

        for (int f = 0; f < 3; f++) frame(16 * f);
        idle(12);

        for (int k = 0; k < N; k++) begin
            drive(1, DW'(k), 0);
            if (k < N - 1) idle(2);
        end
        idle(12);

        for (int k = 0; k < 5; k++) drive(1, DW'(8'h55 + k), 0);
        drive(0, '0, 1);
        frame('h100);
        idle(12);

        frame('h200);
        idle(4);
        drive(0, '0, 1);
        frame('h300);
        idle(12);

        drive(1, DW'($urandom), 1);
        for (int f = 0; f < 30; f++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 59) == 0) drive($urandom_range(0, 1) == 1, DW'($urandom), 1);
                while ($urandom_range(0, 2) == 0) drive(0, DW'($urandom), 0);
                drive(1, DW'($urandom), 0);
            end
        end

        idle(N + 6);
        done = 1;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
